// File: rtl/can_rx_destuff.sv
// CAN receive bit-destuffing and frame-start stage.
// Watches the sampled bus bits for idle, start of frame and stuff bits.
// It flags the stuff bit so downstream CRC and shift logic can skip it,
// and it emits the destuffed data bits as one-clk pulses.
module can_rx_destuff #(
  parameter int IDLE_BITS         = 11,
  parameter int INTERMISSION_BITS = 3,
  parameter int STUFF_LEN         = 5
) (
  input  logic clk,
  input  logic nRST,
  input  logic bitstrobe,
  input  logic CANRX,
  input  logic stuff_en,
  input  logic frame_end,
  output logic SOF,
  output logic bitstuff,
  output logic rx_valid,
  output logic rx_bit,
  output logic stuff_err,
  output logic bus_idle
);

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    FRAME,
    NOSTUFF
  } state_t;

  localparam logic [3:0] IDLE_NEED  = 4'(IDLE_BITS);
  localparam logic [3:0] INTER_NEED = 4'(INTERMISSION_BITS);
  localparam logic [2:0] STUFF_RUN  = 3'(STUFF_LEN);

  state_t     state_q, state_d;
  logic       prev_q, prev_d;
  logic [2:0] run_q, run_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [3:0] need_q, need_d;
  logic       sof_q, sof_d;
  logic       bitstuff_q, bitstuff_d;
  logic       rx_valid_q, rx_valid_d;
  logic       rx_bit_q, rx_bit_d;
  logic       stuff_err_q, stuff_err_d;
  logic       bus_idle_q, bus_idle_d;

  logic [2:0] run_next;
  logic [3:0] rcnt_next;

  // State and output registers; reset leaves the block hunting for a full idle period.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q     <= WAIT_IDLE;
      prev_q      <= 1'b0;
      run_q       <= 3'd0;
      rcnt_q      <= 4'd0;
      need_q      <= IDLE_NEED;
      sof_q       <= 1'b0;
      bitstuff_q  <= 1'b0;
      rx_valid_q  <= 1'b0;
      rx_bit_q    <= 1'b0;
      stuff_err_q <= 1'b0;
      bus_idle_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_q      <= prev_d;
      run_q       <= run_d;
      rcnt_q      <= rcnt_d;
      need_q      <= need_d;
      sof_q       <= sof_d;
      bitstuff_q  <= bitstuff_d;
      rx_valid_q  <= rx_valid_d;
      rx_bit_q    <= rx_bit_d;
      stuff_err_q <= stuff_err_d;
      bus_idle_q  <= bus_idle_d;
    end
  end

  // Next-state logic: frame_end overrides everything, otherwise act only on a bit strobe.
  always_comb begin
    state_d     = state_q;
    prev_d      = prev_q;
    run_d       = run_q;
    rcnt_d      = rcnt_q;
    need_d      = need_q;
    sof_d       = 1'b0;
    rx_valid_d  = 1'b0;
    stuff_err_d = 1'b0;
    rx_bit_d    = rx_bit_q;
    bitstuff_d  = bitstuff_q;
    bus_idle_d  = bus_idle_q;
    run_next    = 3'd1;
    rcnt_next   = 4'd0;

    if (frame_end && (state_q != WAIT_IDLE)) begin
      state_d    = WAIT_IDLE;
      need_d     = INTER_NEED;
      rcnt_d     = 4'd0;
      bitstuff_d = 1'b0;
      bus_idle_d = 1'b0;
    end else if (bitstrobe) begin
      case (state_q)
        WAIT_IDLE: begin
          if (CANRX) begin
            rcnt_next = (rcnt_q == 4'hF) ? rcnt_q : rcnt_q + 4'd1;
          end
          rcnt_d = rcnt_next;
          if (CANRX && (rcnt_next >= need_q)) begin
            state_d    = IDLE;
            bus_idle_d = 1'b1;
          end
        end
        IDLE: begin
          if (!CANRX) begin
            sof_d      = 1'b1;
            prev_d     = 1'b0;
            run_d      = 3'd1;
            bus_idle_d = 1'b0;
            state_d    = FRAME;
          end
        end
        FRAME: begin
          if (!stuff_en) begin
            state_d    = NOSTUFF;
            bitstuff_d = 1'b0;
            rx_valid_d = 1'b1;
            rx_bit_d   = CANRX;
            prev_d     = CANRX;
          end else if (bitstuff_q) begin
            if (CANRX == prev_q) begin
              stuff_err_d = 1'b1;
              state_d     = WAIT_IDLE;
              need_d      = IDLE_NEED;
              rcnt_d      = 4'd0;
              bitstuff_d  = 1'b0;
            end else begin
              prev_d     = CANRX;
              run_d      = 3'd1;
              bitstuff_d = 1'b0;
            end
          end else begin
            if (CANRX == prev_q) begin
              run_next = run_q + 3'd1;
            end
            run_d      = run_next;
            prev_d     = CANRX;
            rx_valid_d = 1'b1;
            rx_bit_d   = CANRX;
            bitstuff_d = (run_next == STUFF_RUN);
          end
        end
        NOSTUFF: begin
          rx_valid_d = 1'b1;
          rx_bit_d   = CANRX;
          prev_d     = CANRX;
          bitstuff_d = 1'b0;
        end
        default: begin
          state_d = WAIT_IDLE;
        end
      endcase
    end
  end

  assign SOF       = sof_q;
  assign bitstuff  = bitstuff_q;
  assign rx_valid  = rx_valid_q;
  assign rx_bit    = rx_bit_q;
  assign stuff_err = stuff_err_q;
  assign bus_idle  = bus_idle_q;

endmodule

// File: tb/tb_can_rx_destuff.sv
// Testbench for can_rx_destuff: a directed vector table, hand-written
// corner sequences and random frames checked against a bit-history model.
module tb_can_rx_destuff;

  logic clk = 1'b0;
  logic nRST;
  logic bitstrobe;
  logic CANRX;
  logic stuff_en;
  logic frame_end;
  logic SOF;
  logic bitstuff;
  logic rx_valid;
  logic rx_bit;
  logic stuff_err;
  logic bus_idle;

  int checks = 0;
  int failures = 0;

  can_rx_destuff dut (
    .clk       (clk),
    .nRST      (nRST),
    .bitstrobe (bitstrobe),
    .CANRX     (CANRX),
    .stuff_en  (stuff_en),
    .frame_end (frame_end),
    .SOF       (SOF),
    .bitstuff  (bitstuff),
    .rx_valid  (rx_valid),
    .rx_bit    (rx_bit),
    .stuff_err (stuff_err),
    .bus_idle  (bus_idle)
  );

  // 10 ns system clock.
  always #5 clk = ~clk;

  // Reference model: phases plus the raw history of bus bits.
  localparam int PH_WAIT    = 0;
  localparam int PH_IDLE    = 1;
  localparam int PH_FRAME   = 2;
  localparam int PH_NOSTUFF = 3;

  int phase;
  int need;
  bit waitBits[$];
  bit frameBits[$];
  bit mSof, mValid, mBit, mStuff, mErr, mIdle;

  typedef struct {
    bit st;
    bit fe;
    bit b;
    bit se;
    bit sof;
    bit v;
    bit rb;
    bit bs;
    bit er;
    bit id;
  } vec_t;

  vec_t tbl[$];

  function automatic void enterWait(int n);
    phase = PH_WAIT;
    need  = n;
    waitBits.delete();
  endfunction

  function automatic void modelReset();
    enterWait(11);
    frameBits.delete();
    mSof = 0; mValid = 0; mBit = 0; mStuff = 0; mErr = 0; mIdle = 0;
  endfunction

  function automatic int trailingOnes();
    int cnt = 0;
    for (int k = waitBits.size() - 1; k >= 0; k--) begin
      if (!waitBits[k]) break;
      cnt++;
    end
    return cnt;
  endfunction

  function automatic bit lastFiveEqual();
    int n = frameBits.size();
    if (n < 5) return 1'b0;
    for (int k = 1; k < 5; k++) begin
      if (frameBits[n-1-k] != frameBits[n-1]) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic void modelStrobe(bit b, bit se);
    case (phase)
      PH_WAIT: begin
        waitBits.push_back(b);
        if (trailingOnes() >= need) begin
          phase = PH_IDLE;
          mIdle = 1;
        end
      end
      PH_IDLE: begin
        if (!b) begin
          mSof  = 1;
          mIdle = 0;
          frameBits.delete();
          frameBits.push_back(1'b0);
          phase = PH_FRAME;
        end
      end
      PH_FRAME: begin
        if (!se) begin
          phase  = PH_NOSTUFF;
          mValid = 1;
          mBit   = b;
          mStuff = 0;
        end else if (mStuff) begin
          mStuff = 0;
          if (b == frameBits[frameBits.size()-1]) begin
            mErr = 1;
            enterWait(11);
          end else begin
            frameBits.push_back(b);
          end
        end else begin
          mValid = 1;
          mBit   = b;
          frameBits.push_back(b);
          mStuff = lastFiveEqual();
        end
      end
      default: begin
        mValid = 1;
        mBit   = b;
      end
    endcase
  endfunction

  function automatic void modelFrameEnd();
    enterWait(3);
    mStuff = 0;
    mIdle  = 0;
  endfunction

  task automatic checkBit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic checkInt(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkOutput(string tag, bit eSof, bit eValid, bit eBit,
                             bit eStuff, bit eErr, bit eIdle);
    checkBit({tag, ".SOF"}, SOF, eSof);
    checkBit({tag, ".rx_valid"}, rx_valid, eValid);
    checkBit({tag, ".rx_bit"}, rx_bit, eBit);
    checkBit({tag, ".bitstuff"}, bitstuff, eStuff);
    checkBit({tag, ".stuff_err"}, stuff_err, eErr);
    checkBit({tag, ".bus_idle"}, bus_idle, eIdle);
  endtask

  task automatic checkModel(string tag);
    checkOutput(tag, mSof, mValid, mBit, mStuff, mErr, mIdle);
  endtask

  // Drive one clock cycle starting 1 ns after a rising edge; ends 1 ns after the next one.
  task automatic applyStimulus(bit st, bit fe, bit b, bit se);
    bitstrobe = st;
    frame_end = fe;
    CANRX     = b;
    stuff_en  = se;
    @(posedge clk);
    #1;
    bitstrobe = 1'b0;
    frame_end = 1'b0;
    mSof = 0; mValid = 0; mErr = 0;
    if (fe && phase != PH_WAIT) modelFrameEnd();
    else if (st) modelStrobe(b, se);
  endtask

  task automatic bitAndGap(bit b, bit se, string tag);
    applyStimulus(1'b1, 1'b0, b, se);
    checkModel(tag);
    applyStimulus(1'b0, 1'b0, b, se);
    checkModel({tag, "_gap"});
  endtask

  function automatic void addVec(bit st, bit fe, bit b, bit se, bit sof, bit v,
                                 bit rb, bit bs, bit er, bit id);
    vec_t r;
    r = '{st, fe, b, se, sof, v, rb, bs, er, id};
    tbl.push_back(r);
  endfunction

  // Hard time limit so a stuck run still reports.
  initial begin
    #1500000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int validSeen;
    int stuffSeen;
    int errSeen;
    int n;
    int seLen;
    bit b;
    bit se;

    nRST = 1'b0; bitstrobe = 1'b0; CANRX = 1'b1; stuff_en = 1'b1; frame_end = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
    nRST = 1'b1;

    // Directed vectors: idle detection, stuffed frame, intermission, stuff error.
    repeat (10) addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    repeat (3) addVec(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 1, 0, 1, 0, 0);
    addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    addVec(1, 0, 0, 1, 0, 1, 0, 0, 0, 0);
    addVec(0, 1, 1, 1, 0, 0, 0, 0, 0, 0);
    repeat (2) addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
    addVec(1, 0, 1, 1, 0, 0, 0, 0, 0, 1);
    addVec(1, 0, 0, 1, 1, 0, 0, 0, 0, 0);
    repeat (4) addVec(1, 0, 1, 1, 0, 1, 1, 0, 0, 0);
    addVec(1, 0, 1, 1, 0, 1, 1, 1, 0, 0);
    addVec(1, 0, 1, 1, 0, 0, 1, 0, 1, 0);
    addVec(1, 0, 0, 1, 0, 0, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      applyStimulus(tbl[i].st, tbl[i].fe, tbl[i].b, tbl[i].se);
      checkOutput($sformatf("vec%0d", i), tbl[i].sof, tbl[i].v, tbl[i].rb,
                  tbl[i].bs, tbl[i].er, tbl[i].id);
      applyStimulus(1'b0, 1'b0, tbl[i].b, tbl[i].se);
      checkOutput($sformatf("vec%0d_gap", i), 1'b0, 1'b0, tbl[i].rb,
                  tbl[i].bs, 1'b0, tbl[i].id);
    end

    // Full idle after the stuff error, then a frame with destuffing disabled.
    for (int i = 0; i < 11; i++) bitAndGap(1'b1, 1'b1, $sformatf("reidle%0d", i));
    bitAndGap(1'b0, 1'b1, "nostuff_sof");
    validSeen = 0; stuffSeen = 0; errSeen = 0;
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
      validSeen += int'(rx_valid);
      stuffSeen += int'(bitstuff);
      errSeen   += int'(stuff_err);
      checkModel($sformatf("nostuff%0d", i));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      stuffSeen += int'(bitstuff);
    end
    checkInt("nostuff_valid_count", validSeen, 8);
    checkInt("nostuff_bitstuff_count", stuffSeen, 0);
    checkInt("nostuff_err_count", errSeen, 0);

    // Short intermission (2 recessive) must not allow SOF; 3 must.
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkModel("fe1");
    bitAndGap(1'b1, 1'b1, "short_r0");
    bitAndGap(1'b1, 1'b1, "short_r1");
    bitAndGap(1'b0, 1'b1, "short_dom");
    for (int i = 0; i < 3; i++) bitAndGap(1'b1, 1'b1, $sformatf("inter%0d", i));
    bitAndGap(1'b0, 1'b1, "inter_sof");

    // stuff_en drops on the strobe that would raise bitstuff.
    for (int i = 0; i < 3; i++) bitAndGap(1'b0, 1'b1, $sformatf("drop%0d", i));
    bitAndGap(1'b0, 1'b0, "drop_edge");
    // frame_end coincident with a strobe discards the bit.
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
    checkModel("fe_with_strobe");

    // Asynchronous reset while bitstuff is high.
    for (int i = 0; i < 3; i++) bitAndGap(1'b1, 1'b1, $sformatf("pre%0d", i));
    bitAndGap(1'b0, 1'b1, "rst_sof");
    for (int i = 0; i < 4; i++) bitAndGap(1'b0, 1'b1, $sformatf("rst_run%0d", i));
    checkBit("rst_bitstuff_before", bitstuff, 1'b1);
    #2;
    nRST = 1'b0;
    #1;
    checkOutput("async_reset", 0, 0, 0, 0, 0, 0);
    modelReset();
    @(posedge clk);
    #1;
    nRST = 1'b1;
    for (int i = 0; i < 10; i++) bitAndGap(1'b1, 1'b1, $sformatf("postrst%0d", i));
    bitAndGap(1'b1, 1'b1, "postrst_idle");
    bitAndGap(1'b0, 1'b1, "postrst_sof");
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1);
    checkModel("postrst_fe");

    // Random frames against the model.
    for (int f = 0; f < 30; f++) begin
      for (int g = 0; g < 40 && phase != PH_IDLE; g++) begin
        b = ($urandom_range(0, 9) == 0) ? 1'b0 : 1'b1;
        bitAndGap(b, 1'b1, $sformatf("r%0d_pre%0d", f, g));
      end
      bitAndGap(1'b0, 1'b1, $sformatf("r%0d_sof", f));
      n = $urandom_range(10, 40);
      seLen = n - $urandom_range(0, 3);
      for (int i = 0; i < n; i++) begin
        if (phase != PH_FRAME && phase != PH_NOSTUFF) break;
        se = (i < seLen);
        b = 1'($urandom_range(0, 1));
        if (phase == PH_FRAME && mStuff && $urandom_range(0, 7) != 0)
          b = ~frameBits[frameBits.size()-1];
        bitAndGap(b, se, $sformatf("r%0d_b%0d", f, i));
      end
      applyStimulus(1'($urandom_range(0, 1)), 1'b1, 1'b1, 1'b0);
      checkModel($sformatf("r%0d_fe", f));
      applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
      checkModel($sformatf("r%0d_fe_gap", f));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_destuff.md
Name: can_rx_destuff

Overview:
- Receive-side bit-destuffing and frame-start stage of the CAN controller.
- Sits between the bit-timing unit, which provides the `bitstrobe` sample pulse, and the CRC checker / frame decoder.
- Detects bus idle, start of frame (SOF), stuff bits and stuff errors.
- Drives `bitstuff` so that downstream CRC and shift logic skip stuff bits, and emits a destuffed bit stream.

Parameters:
- IDLE_BITS, 11, consecutive recessive bits required after reset or after `stuff_err` before SOF is accepted.
- INTERMISSION_BITS, 3, consecutive recessive bits required after `frame_end` before SOF is accepted.
- STUFF_LEN, 5, run length of equal bits after which a stuff bit is expected.

Ports:
- clk  input  1  system clock.
- nRST  input  1  reset, asynchronous, active-low.
- bitstrobe  input  1  one-clk pulse at the sample point of each bus bit.
- CANRX  input  1  synchronised receive line (1 = recessive).
- stuff_en  input  1  from frame decoder; high while destuffing applies (SOF through end of CRC sequence), low from CRC delimiter on.
- frame_end  input  1  one-clk pulse from frame decoder: frame complete or aborted.
- SOF  output  1  one-clk pulse, start of frame detected.
- bitstuff  output  1  current bus bit is a stuff bit.
- rx_valid  output  1  one-clk pulse, `rx_bit` holds a new destuffed bit.
- rx_bit  output  1  destuffed data bit.
- stuff_err  output  1  one-clk pulse, stuff rule violated.
- bus_idle  output  1  block is waiting in IDLE for SOF.

Behaviour:
- All outputs are registered; reset value 0 for every output. On reset, state = WAIT_IDLE with the recessive counter at 0.
- Internal registers: `prev` (last sampled bit), `run` (3-bit equal-bit run length; stuff bits count), `rcnt` (4-bit recessive counter), `need` (IDLE_BITS or INTERMISSION_BITS).
- All state updates occur only in the cycle `bitstrobe` = 1. Outputs change on the following clk edge, i.e. 1 clk after `bitstrobe`.
- States:
  - WAIT_IDLE: on each strobe, CANRX = 1 → `rcnt` += 1 (saturating); CANRX = 0 → `rcnt` = 0. When `rcnt` reaches `need`, go to IDLE and set `bus_idle` = 1.
  - IDLE: a strobe with CANRX = 0 → pulse SOF, `prev` = 0, `run` = 1, `bus_idle` = 0, go to FRAME. The SOF bit itself produces no `rx_valid`.
  - FRAME (`stuff_en` = 1):
    - Strobe while `bitstuff` = 1: the sampled bit is a stuff bit. If CANRX == `prev` → pulse `stuff_err`, go to WAIT_IDLE with `need` = IDLE_BITS, `rcnt` = 0. Otherwise `prev` = CANRX, `run` = 1, clear `bitstuff`, no `rx_valid`.
    - Normal strobe: pulse `rx_valid` with `rx_bit` = CANRX. If CANRX == `prev`, `run` += 1; else `run` = 1. `prev` = CANRX. If the new `run` == STUFF_LEN, set `bitstuff` = 1 (held until the next strobe's update).
  - NOSTUFF (entered whenever `stuff_en` = 0 in FRAME): every strobe gives `rx_valid`; `bitstuff` is forced 0; no stuff checking.
- Timing of `bitstuff`: it is asserted from 1 clk after the 5th equal bit's strobe through the stuff bit's strobe cycle, so downstream gating (`bitstrobe` & ~`bitstuff`) suppresses exactly the stuff bit.
- `frame_end` in FRAME/NOSTUFF/IDLE → WAIT_IDLE with `need` = INTERMISSION_BITS, `rcnt` = 0, `bitstuff` = 0.
- Simultaneous events:
  - `frame_end` with `bitstrobe`: `frame_end` wins; the bit is discarded.
  - `stuff_en` falling on the same clk that `bitstuff` would be set: `bitstuff` stays 0.
- Reset mid-frame returns to WAIT_IDLE; a full IDLE_BITS of recessive is then required before SOF.

Test Plan:
- Reset, CANRX = 1 for 10 strobes → `bus_idle` = 0; 11th strobe → `bus_idle` = 1 one clk later; CANRX = 0 next strobe → SOF pulse, `bus_idle` = 0.
- After SOF, bits 0,0,0,0 then stuff bit 1, then 1,0 → `bitstuff` = 1 after the 4th 0 (run = 5 including SOF) through the stuff strobe. `rx_valid` on 6 bits with `rx_bit` = 0,0,0,0,1,0; none for the stuff bit.
- After SOF, bits 1,1,1,1,1 then 1 at the stuff position → `stuff_err` pulse 1 clk after the 6th strobe, `rx_valid` not asserted for it, state WAIT_IDLE; SOF ignored until 11 recessive bits.
- `stuff_en` = 0, then 8 recessive bits → 8 `rx_valid` pulses, `bitstuff` never asserted, no `stuff_err`.
- `frame_end` pulse, then 3 recessive strobes then dominant → SOF. With 2 recessive then dominant → no SOF, `rcnt` restarts.
- nRST low mid-frame while `bitstuff` = 1 → all outputs 0 immediately (asynchronous); after release, SOF requires 11 recessive bits.
